// File: rtl/tqvp_bus_pkg.sv
// Shared definitions for the TinyQV bus initiator: size encodings, idle strobe,
// FSM states, the queued command layout and the size-to-byte-mask helper.
package tqvp_bus_pkg;

  localparam logic [1:0] SZ_8        = 2'b00;
  localparam logic [1:0] SZ_16       = 2'b01;
  localparam logic [1:0] SZ_32       = 2'b10;
  localparam logic [1:0] SZ_BAD      = 2'b11;
  localparam logic [1:0] STROBE_IDLE = 2'b11;

  localparam int CMD_W = 41;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    logic [31:0] mask;
    case (size)
      SZ_8:    mask = 32'h0000_00FF;
      SZ_16:   mask = 32'h0000_FFFF;
      SZ_32:   mask = 32'hFFFF_FFFF;
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/tqvp_cmd_fifo.sv
// Synchronous command FIFO. Flags derive from a registered occupancy count only,
// so the upstream ready never depends combinationally on the consumer.
module tqvp_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign data_o    = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop_s && !do_push_s) begin
      count_d = count_q - (AW+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/tqvp_bus_initiator.sv
// Replays queued commands onto the TinyQV peripheral bus, one access at a time,
// and returns exactly one response per command.
import tqvp_bus_pkg::*;

module tqvp_bus_initiator #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [5:0]  per_address,
  output logic [31:0] per_data_in,
  output logic [1:0]  per_data_write_n,
  output logic [1:0]  per_data_read_n,
  input  logic [31:0] per_data_out,
  input  logic        per_data_ready,
  output logic        busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [1:0]  wn_q, wn_d;
  logic [1:0]  rn_q, rn_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsize_q, rsize_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             fifo_pop_s;
  logic [CMD_W-1:0] fifo_head_raw_s;
  cmd_t             head_s;
  cmd_t             push_cmd_s;

  assign push_cmd_s = '{write: cmd_write, size: cmd_size, addr: cmd_addr, wdata: cmd_wdata};
  assign head_s     = cmd_t'(fifo_head_raw_s);

  tqvp_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid),
    .data_i  (push_cmd_s),
    .pop_i   (fifo_pop_s),
    .data_o  (fifo_head_raw_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign cmd_ready        = ~fifo_full_s;
  assign busy             = (state_q != ST_IDLE) | ~fifo_empty_s;
  assign per_address      = addr_q;
  assign per_data_in      = din_q;
  assign per_data_write_n = wn_q;
  assign per_data_read_n  = rn_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_write        = rsp_write_q;
  assign rsp_err          = rsp_err_q;
  assign rsp_rdata        = rsp_rdata_q;

  // Access sequencer: next state plus next value of every registered output.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    din_d       = din_q;
    wn_d        = wn_q;
    rn_d        = rn_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsize_d     = rsize_q;
    tmo_d       = tmo_q;
    fifo_pop_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          rsize_d    = head_s.size;
          if (head_s.size == SZ_BAD) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_write_d = head_s.write;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0000_0000;
          end else if (head_s.write) begin
            state_d = ST_WRITE;
            wn_d    = head_s.size;
            addr_d  = head_s.addr;
            din_d   = head_s.wdata & size_mask(head_s.size);
          end else begin
            state_d = ST_READ;
            rn_d    = head_s.size;
            addr_d  = head_s.addr;
            tmo_d   = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        wn_d        = STROBE_IDLE;
        din_d       = 32'h0000_0000;
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
      end
      ST_READ: begin
        if (per_data_ready) begin
          rn_d        = STROBE_IDLE;
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = per_data_out & size_mask(rsize_q);
        end else if (tmo_q == TMO_LAST) begin
          // This edge is the TIMEOUT_CYCLES-th consecutive one without ready.
          rn_d        = STROBE_IDLE;
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0000_0000;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_write_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0000_0000;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        wn_d        = STROBE_IDLE;
        rn_d        = STROBE_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= 6'd0;
      din_q       <= 32'h0000_0000;
      wn_q        <= STROBE_IDLE;
      rn_q        <= STROBE_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsize_q     <= SZ_8;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      wn_q        <= wn_d;
      rn_q        <= rn_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsize_q     <= rsize_d;
      tmo_q       <= tmo_d;
    end
  end

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Directed bench for tqvp_bus_initiator: a response scoreboard fed at command issue,
// a monitor that pops on every response handshake, and a delayed-ready peripheral model.
module tb_tqvp_bus_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_size;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic [5:0]  per_address;
  logic [31:0] per_data_in;
  logic [1:0]  per_data_write_n, per_data_read_n;
  logic [31:0] per_data_out;
  logic        per_data_ready;
  logic        busy;

  typedef struct packed {
    logic        write;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rd_delay = 0;
  int   rd_cnt   = 0;

  always #5 clk = ~clk;

  tqvp_bus_initiator #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_size         (cmd_size),
    .cmd_addr         (cmd_addr),
    .cmd_wdata        (cmd_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_write        (rsp_write),
    .rsp_err          (rsp_err),
    .rsp_rdata        (rsp_rdata),
    .per_address      (per_address),
    .per_data_in      (per_data_in),
    .per_data_write_n (per_data_write_n),
    .per_data_read_n  (per_data_read_n),
    .per_data_out     (per_data_out),
    .per_data_ready   (per_data_ready),
    .busy             (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Peripheral model: ready rises once the read strobe has been up rd_delay cycles.
  always @(negedge clk) begin
    if (per_data_read_n != 2'b11) begin
      per_data_ready = (rd_cnt >= rd_delay);
      rd_cnt++;
    end else begin
      per_data_ready = 1'b0;
      rd_cnt = 0;
    end
  end

  // Response monitor: compare on every handshake against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_write", {31'b0, rsp_write}, {31'b0, mon_e.write});
        check("rsp_err",   {31'b0, rsp_err},   {31'b0, mon_e.err});
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
      end
    end
  end

  task automatic push(input logic w, input logic [1:0] sz, input logic [5:0] a,
                      input logic [31:0] wd, input bit expect_rsp,
                      input logic e_err, input logic [31:0] e_rd);
    int guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!cmd_ready) begin
      check("push_ready_timeout", {31'b0, cmd_ready}, 32'd1);
      return;
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_size = sz; cmd_addr = a; cmd_wdata = wd;
    if (expect_rsp) exp_q.push_back('{write: w, err: e_err, rdata: e_rd});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_strobe(input bit rd, output int first, output int len,
                             output logic [5:0] a, output logic [31:0] d,
                             output logic [1:0] s, output bit stable);
    logic [1:0] st;
    first = 0; len = 0; a = 6'd0; d = 32'd0; s = 2'b11; stable = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      st = rd ? per_data_read_n : per_data_write_n;
      if (st != 2'b11) begin
        first = i; len = 1; a = per_address; d = per_data_in; s = st;
        break;
      end
    end
    if (len != 0) begin
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        st = rd ? per_data_read_n : per_data_write_n;
        if (st == 2'b11) break;
        len++;
        if (per_address != a) stable = 1'b0;
      end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  int          first, len, activity;
  logic [5:0]  sa;
  logic [31:0] sd;
  logic [1:0]  ss;
  bit          stab;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00;
    cmd_addr = 6'd0; cmd_wdata = 32'd0; rsp_ready = 1'b0;
    per_data_out = 32'd0; per_data_ready = 1'b0;
    #12;
    check("rst_write_n", {30'b0, per_data_write_n}, 32'd3);
    check("rst_read_n",  {30'b0, per_data_read_n},  32'd3);
    check("rst_address", {26'b0, per_address}, 32'd0);
    check("rst_data_in", per_data_in, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_write", {31'b0, rsp_write}, 32'd0);
    check("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 32-bit write
    rsp_ready = 1'b1;
    push(1'b1, 2'b10, 6'd0, 32'hDEADBEEF, 1'b1, 1'b0, 32'd0);
    wait_strobe(1'b0, first, len, sa, sd, ss, stab);
    check("wr32_latency", 32'(first), 32'd2);
    check("wr32_len",     32'(len),   32'd1);
    check("wr32_size",    {30'b0, ss}, 32'd2);
    check("wr32_data",    sd, 32'hDEADBEEF);
    check("wr32_addr",    {26'b0, sa}, 32'd0);
    check("wr32_din_idle", per_data_in, 32'd0);
    drain("wr32_drain");

    // 8-bit read, ready immediately
    rd_delay = 0; per_data_out = 32'h1234_5678;
    push(1'b0, 2'b00, 6'd4, 32'd0, 1'b1, 1'b0, 32'h0000_0078);
    wait_strobe(1'b1, first, len, sa, sd, ss, stab);
    check("rd8_latency", 32'(first), 32'd2);
    check("rd8_len",     32'(len),   32'd1);
    check("rd8_size",    {30'b0, ss}, 32'd0);
    check("rd8_addr",    {26'b0, sa}, 32'd4);
    drain("rd8_drain");

    // 16-bit read, ready after 3 low edges
    rd_delay = 3; per_data_out = 32'hAAAA_BBBB;
    push(1'b0, 2'b01, 6'd5, 32'd0, 1'b1, 1'b0, 32'h0000_BBBB);
    wait_strobe(1'b1, first, len, sa, sd, ss, stab);
    check("rd16_len",    32'(len), 32'd4);
    check("rd16_size",   {30'b0, ss}, 32'd1);
    check("rd16_stable", {31'b0, stab}, 32'd1);
    drain("rd16_drain");

    // 32-bit read timing out
    rd_delay = 1000;
    push(1'b0, 2'b10, 6'd8, 32'd0, 1'b1, 1'b1, 32'd0);
    wait_strobe(1'b1, first, len, sa, sd, ss, stab);
    check("tmo_len",    32'(len), 32'd16);
    check("tmo_stable", {31'b0, stab}, 32'd1);
    drain("tmo_drain");
    check("tmo_idle_busy", {31'b0, busy}, 32'd0);

    // 16-bit write with upper bytes masked off
    push(1'b1, 2'b01, 6'd63, 32'hCAFE_BABE, 1'b1, 1'b0, 32'd0);
    wait_strobe(1'b0, first, len, sa, sd, ss, stab);
    check("wr16_len",  32'(len), 32'd1);
    check("wr16_size", {30'b0, ss}, 32'd1);
    check("wr16_data", sd, 32'h0000_BABE);
    check("wr16_addr", {26'b0, sa}, 32'd63);
    drain("wr16_drain");

    // Illegal size: no strobe, error response
    push(1'b0, 2'b11, 6'd2, 32'd0, 1'b1, 1'b1, 32'd0);
    wait_strobe(1'b1, first, len, sa, sd, ss, stab);
    check("bad_no_strobe", 32'(len), 32'd0);
    drain("bad_drain");

    // Backpressure: five commands with responses stalled
    rsp_ready = 1'b0; rd_delay = 0; per_data_out = 32'h1234_5678;
    push(1'b1, 2'b00, 6'd1, 32'hCAFE_BABE, 1'b1, 1'b0, 32'd0);
    push(1'b0, 2'b00, 6'd2, 32'd0,         1'b1, 1'b0, 32'h0000_0078);
    push(1'b1, 2'b01, 6'd3, 32'h1111_2222, 1'b1, 1'b0, 32'd0);
    push(1'b0, 2'b10, 6'd4, 32'd0,         1'b1, 1'b0, 32'h1234_5678);
    push(1'b1, 2'b11, 6'd5, 32'd0,         1'b1, 1'b1, 32'd0);
    check("full_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    activity = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (per_data_write_n != 2'b11 || per_data_read_n != 2'b11) activity++;
    end
    check("stall_no_bus", 32'(activity), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = 2'b10; cmd_addr = 6'd7; cmd_wdata = 32'h5555_5555;
    repeat (3) begin @(posedge clk); #1; end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain("full_drain");
    repeat (20) begin @(posedge clk); #1; end
    check("full_idle_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset during a read strobe
    rd_delay = 1000;
    push(1'b0, 2'b10, 6'd9,  32'd0, 1'b0, 1'b0, 32'd0);
    push(1'b1, 2'b10, 6'd10, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 40 && per_data_read_n == 2'b11; i++) @(negedge clk);
    check("arst_strobe_seen", {30'b0, per_data_read_n}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_read_n",   {30'b0, per_data_read_n}, 32'd3);
    check("arst_busy",     {31'b0, busy},      32'd0);
    check("arst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    activity = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (per_data_write_n != 2'b11 || per_data_read_n != 2'b11 || rsp_valid) activity++;
    end
    check("arst_quiet", 32'(activity), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
